apb_mem_slave: RTL and testbench

APB completer that sits directly downstream of the APB master block. It is one of the two slave targets selected by address bit 8; the master passes the lower 8 address bits to this block. It implements a DEPTH x DATA_WIDTH register-file memory with a programmable number of wait states and an error response for out-of-range addresses. It terminates the setup/access handshake with PREADY/PSLVERR and returns read data on PRDATA.

---
 rtl/apb_mem_slave.sv | 133 +++++++++++++
 tb/tb_apb_mem_slave.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer backed by a DEPTH x DATA_WIDTH register file. It inserts a fixed
// number of wait states and flags out-of-range addresses with PSLVERR.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;

  // Index is only used when the address is in range, so truncation never aliases.
  assign setup_err = ({1'b0, PADDR} >= DEPTH_C);
  assign setup_idx = PADDR[IDX_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = setup_idx;
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            if (!PWRITE)
              prdata_d = setup_err ? '0 : mem_q[setup_idx];
          end
        end
      end
      ACCESS: begin
        if (!(PSEL && PENABLE)) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q) begin
          mem_we    = write_q && !err_q;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q)
              prdata_d = err_q ? '0 : mem_q[idx_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Writes commit only on the completion edge, after PREADY was seen high.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one instance with two wait states, one with none.
module tb_apb_mem_slave;

  logic       clk;
  logic       prst;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_STATES(2)) dut_ws2 (
    .PCLK(clk), .PRST(prst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(128), .WAIT_STATES(0)) dut_ws0 (
    .PCLK(clk), .PRST(prst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1])
  );

  typedef struct {
    int         d;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Setup on one negedge, access phase from the next; returns with PREADY high
  // so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input logic [7:0] exp_rd,
                      input bit exp_err, input string tag);
    int lows;
    int ws;
    ws = (d == 0) ? 2 : 0;
    @(negedge clk);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
    @(negedge clk);
    penable[d] = 1'b1;
    paddr[d]   = 8'hFF ^ addr;
    pwdata[d]  = 8'hFF ^ data;
    lows = 0;
    while (pready[d] !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    chk({tag, " wait cycles"}, lows, ws);
    chk({tag, " pslverr"}, {31'd0, pslverr[d]}, {31'd0, exp_err});
    chk({tag, " prdata"}, {24'd0, prdata[d]}, {24'd0, exp_rd});
  endtask

  function automatic vec_t mk(int d, bit wr, logic [7:0] a, logic [7:0] dt,
                              logic [7:0] rd, bit er);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = a; v.data = dt; v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  initial begin
    int lows;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
    end

    // Writes leave PRDATA holding the previous read result.
    vecs.push_back(mk(0, 0, 8'h3F, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h3F, 8'h18, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h3F, 8'h00, 8'h18, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 8'(i), 8'(2*i), 8'h18, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 8'(i), 8'h00, 8'(2*i), 0));
    vecs.push_back(mk(0, 1, 8'h90, 8'hAA, 8'h0E, 1));
    vecs.push_back(mk(0, 0, 8'h10, 8'h00, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h90, 8'h00, 8'h00, 1));
    vecs.push_back(mk(1, 1, 8'h01, 8'hC3, 8'h00, 0));
    vecs.push_back(mk(1, 0, 8'h01, 8'h00, 8'hC3, 0));

    prst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        psel[d] = 1'($urandom); penable[d] = 1'($urandom); pwrite[d] = 1'($urandom);
        paddr[d] = 8'($urandom); pwdata[d] = 8'($urandom);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset pready[%0d]", d), {31'd0, pready[d]}, 0);
      chk($sformatf("reset pslverr[%0d]", d), {31'd0, pslverr[d]}, 0);
      chk($sformatf("reset prdata[%0d]", d), {24'd0, prdata[d]}, 0);
      psel[d] = 0; penable[d] = 0;
    end
    prst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0 && vecs[i].d != vecs[i-1].d) idle(vecs[i-1].d);
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
           vecs[i].exp_err, $sformatf("vec%0d", i));
    end
    idle(1);
    idle(0);

    // PSEL+PENABLE together while idle is not a setup phase.
    @(negedge clk);
    psel[0] = 1; penable[0] = 1; pwrite[0] = 1; paddr[0] = 8'h02; pwdata[0] = 8'h77;
    repeat (3) @(negedge clk);
    chk("no-setup pready", {31'd0, pready[0]}, 0);
    psel[0] = 0; penable[0] = 0;

    // Abort: PSEL dropped in the first wait cycle.
    @(negedge clk);
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h05; pwdata[0] = 8'h55;
    @(negedge clk);
    psel[0] = 0;
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      if (pready[0] !== 1'b0) lows++;
      @(negedge clk);
    end
    chk("abort pready seen", lows, 0);
    xfer(0, 0, 8'h05, 8'h00, 8'h0A, 0, "abort readback");
    xfer(0, 0, 8'h02, 8'h00, 8'h04, 0, "no-setup readback");

    // Reset during ACCESS of a write to 0x06.
    xfer(0, 1, 8'h06, 8'h66, 8'h04, 0, "pre-reset write");
    @(negedge clk);
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h06; pwdata[0] = 8'h66;
    @(negedge clk);
    penable[0] = 1;
    @(negedge clk);
    prst = 1'b1;
    @(negedge clk);
    chk("midreset pready", {31'd0, pready[0]}, 0);
    chk("midreset pslverr", {31'd0, pslverr[0]}, 0);
    chk("midreset prdata", {24'd0, prdata[0]}, 0);
    prst = 1'b0;
    psel[0] = 0; penable[0] = 0;
    xfer(0, 0, 8'h05, 8'h00, 8'h00, 0, "post-reset rd05");
    xfer(0, 0, 8'h06, 8'h00, 8'h00, 0, "post-reset rd06");
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
